// File: rtl/alu_seq_param_pkg.sv
// Shared opcodes, FSM encoding, compare codes and flag bundle for the sequential ALU.
package alu_seq_param_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_EQ   = 4'hA;
  localparam logic [3:0] OP_GT   = 4'hB;
  localparam logic [3:0] OP_LT   = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_DIV_BUSY = 1'b1;

  localparam int unsigned CMP_EQ = 1;
  localparam int unsigned CMP_GT = 2;
  localparam int unsigned CMP_LT = 3;

  typedef struct packed {
    logic arith;
    logic logic_op;
    logic cmp;
    logic shift;
    logic zero;
    logic carry;
    logic div_zero;
  } alu_flags_t;

  // Class flag for an opcode; zero/carry/div_zero are left clear for the caller.
  function automatic alu_flags_t class_flags(input logic [3:0] fun);
    alu_flags_t f;
    f = '0;
    case (fun)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV:                      f.arith    = 1'b1;
      OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR:     f.logic_op = 1'b1;
      OP_EQ, OP_GT, OP_LT:                                 f.cmp      = 1'b1;
      OP_SHR, OP_SHL:                                      f.shift    = 1'b1;
      default:                                             f          = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_param_if.sv
// Operand/result handshake bundle between the register-read stage and the ALU.
interface alu_seq_param_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_fun;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             arith_flag;
  logic             logic_flag;
  logic             cmp_flag;
  logic             shift_flag;
  logic             zero_flag;
  logic             carry_flag;
  logic             divzero_flag;

  modport master (
    output in_valid, a, b, alu_fun, out_ready,
    input  in_ready, out_valid, alu_out, arith_flag, logic_flag, cmp_flag, shift_flag,
           zero_flag, carry_flag, divzero_flag
  );

  modport slave (
    input  in_valid, a, b, alu_fun, out_ready,
    output in_ready, out_valid, alu_out, arith_flag, logic_flag, cmp_flag, shift_flag,
           zero_flag, carry_flag, divzero_flag
  );
endinterface

// File: rtl/alu_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first, WIDTH busy cycles.
module alu_seq_divider
  import alu_seq_param_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int unsigned CntW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             last;

  assign last = busy_q && (cnt_q == CntW'(WIDTH - 1));

  // One restoring step per busy cycle; bit WIDTH of trial is the borrow.
  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      dvd_d  = dividend;
      dvs_d  = divisor;
      quo_d  = '0;
      rem_d  = '0;
    end else if (busy_q) begin
      dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CntW'(1);
      if (last) busy_d = 1'b0;
    end
  end

  // Divider state; reset discards any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
    end
  end

  assign busy     = busy_q;
  assign done     = last;
  // Final quotient includes the bit resolved in the last busy cycle.
  assign quotient = quo_d;

endmodule

// File: rtl/alu_seq_param.sv
// Handshaked parametrised ALU: single-cycle ops plus an iterative divide, registered result.
module alu_seq_param
  import alu_seq_param_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  alu_seq_param_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned PROD_W  = 2 * WIDTH;

  logic [0:0]        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  alu_out_q, alu_out_d;
  alu_flags_t        flags_q, flags_d;

  logic              in_ready;
  logic              accept;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [WIDTH-1:0]  div_quotient;

  logic [WIDTH-1:0]  res;
  alu_flags_t        res_flags;
  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    diff;
  logic [PROD_W-1:0] prod;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready  = (state_q == ST_IDLE) && !div_busy && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign div_start = accept && (bus.alu_fun == OP_DIV) && (bus.b != '0);

  alu_seq_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (bus.a),
    .divisor  (bus.b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Single-cycle datapath; DIV here only covers the divide-by-zero result.
  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};
    prod      = PROD_W'(bus.a) * PROD_W'(bus.b);
    shamt     = bus.b[SHAMT_W-1:0];
    res       = '0;
    res_flags = class_flags(bus.alu_fun);
    case (bus.alu_fun)
      OP_ADD: begin
        res             = sum[WIDTH-1:0];
        res_flags.carry = sum[WIDTH];
      end
      OP_SUB: begin
        res             = diff[WIDTH-1:0];
        res_flags.carry = diff[WIDTH];
      end
      OP_MUL: begin
        res             = prod[WIDTH-1:0];
        res_flags.carry = |prod[PROD_W-1:WIDTH];
      end
      OP_DIV: begin
        res                = '1;
        res_flags.div_zero = 1'b1;
      end
      OP_AND:  res = bus.a & bus.b;
      OP_OR:   res = bus.a | bus.b;
      OP_NAND: res = ~(bus.a & bus.b);
      OP_NOR:  res = ~(bus.a | bus.b);
      OP_XOR:  res = bus.a ^ bus.b;
      OP_XNOR: res = ~(bus.a ^ bus.b);
      OP_EQ:   res = (bus.a == bus.b) ? WIDTH'(CMP_EQ) : '0;
      OP_GT:   res = (bus.a > bus.b)  ? WIDTH'(CMP_GT) : '0;
      OP_LT:   res = (bus.a < bus.b)  ? WIDTH'(CMP_LT) : '0;
      OP_SHR:  res = bus.a >> shamt;
      OP_SHL:  res = bus.a << shamt;
      default: res = '0;
    endcase
    res_flags.zero = (res == '0);
  end

  // FSM: leave IDLE only for a real divide, return when the divider finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (div_start) state_d = ST_DIV_BUSY;
      ST_DIV_BUSY: if (div_done)  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output register: consume clears valid, a new result (same cycle allowed) reloads it.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (div_done) begin
      alu_out_d     = div_quotient;
      flags_d       = '0;
      flags_d.arith = 1'b1;
      flags_d.zero  = (div_quotient == '0);
      out_valid_d   = 1'b1;
    end else if (accept && !div_start) begin
      alu_out_d   = res;
      flags_d     = res_flags;
      out_valid_d = 1'b1;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.alu_out      = alu_out_q;
  assign bus.arith_flag   = flags_q.arith;
  assign bus.logic_flag   = flags_q.logic_op;
  assign bus.cmp_flag     = flags_q.cmp;
  assign bus.shift_flag   = flags_q.shift;
  assign bus.zero_flag    = flags_q.zero;
  assign bus.carry_flag   = flags_q.carry;
  assign bus.divzero_flag = flags_q.div_zero;

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param: directed vector table, handshake corner sequences, random stream.
module tb_alu_seq_param;
  import alu_seq_param_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_seq_param_if #(.WIDTH(16)) bus16 ();
  alu_seq_param_if #(.WIDTH(8))  bus8 ();

  alu_seq_param #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  alu_seq_param #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order in all expectations: {arith, logic, cmp, shift, zero, carry, divzero}.
  typedef struct {
    logic [3:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic [6:0]  efl;
    int          lat;
  } vec_t;

  vec_t vecs[22];

  function automatic logic [6:0] fl16();
    return {bus16.arith_flag, bus16.logic_flag, bus16.cmp_flag, bus16.shift_flag,
            bus16.zero_flag, bus16.carry_flag, bus16.divzero_flag};
  endfunction

  function automatic logic [6:0] fl8();
    return {bus8.arith_flag, bus8.logic_flag, bus8.cmp_flag, bus8.shift_flag,
            bus8.zero_flag, bus8.carry_flag, bus8.divzero_flag};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: 16-bit ALU semantics from plain integer arithmetic.
  function automatic void ref16(input logic [3:0] f, input logic [15:0] a16,
                                input logic [15:0] b16, output logic [15:0] o,
                                output logic [6:0] fl);
    longint unsigned a, b, r;
    bit ar, lg, cm, sh, cy, dz;
    a = 64'(a16); b = 64'(b16); r = 0;
    ar = 0; lg = 0; cm = 0; sh = 0; cy = 0; dz = 0;
    case (f)
      4'h0: begin ar = 1; r = a + b; cy = (r > 65535); end
      4'h1: begin ar = 1; r = a + 65536 - b; cy = (a < b); end
      4'h2: begin ar = 1; r = a * b; cy = (r > 65535); end
      4'h3: begin ar = 1; if (b == 0) begin r = 65535; dz = 1; end else r = a / b; end
      4'h4: begin lg = 1; r = a & b; end
      4'h5: begin lg = 1; r = a | b; end
      4'h6: begin lg = 1; r = ~(a & b); end
      4'h7: begin lg = 1; r = ~(a | b); end
      4'h8: begin lg = 1; r = a ^ b; end
      4'h9: begin lg = 1; r = ~(a ^ b); end
      4'hA: begin cm = 1; r = (a == b) ? 1 : 0; end
      4'hB: begin cm = 1; r = (a > b) ? 2 : 0; end
      4'hC: begin cm = 1; r = (a < b) ? 3 : 0; end
      4'hD: begin sh = 1; r = a >> (b % 16); end
      4'hE: begin sh = 1; r = a << (b % 16); end
      default: r = 0;
    endcase
    o  = r[15:0];
    fl = {ar, lg, cm, sh, (o == 16'h0), cy, dz};
  endfunction

  // Issue one op on the 16-bit DUT with OUT_READY high; check latency, IN_READY and result.
  task automatic op16(input int idx, input logic [3:0] f, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] eo, input logic [6:0] efl,
                      input int elat);
    int lat, low_rdy;
    bit seen;
    bus16.out_ready = 1'b1;
    bus16.in_valid  = 1'b1;
    bus16.alu_fun   = f;
    bus16.a         = a;
    bus16.b         = b;
    chk($sformatf("vec%0d_in_ready", idx), bus16.in_ready, 1);
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    bus16.alu_fun  = 4'($urandom);
    bus16.a        = 16'($urandom);
    bus16.b        = 16'($urandom);
    lat = 0; low_rdy = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus16.out_valid) seen = 1;
      else if (!bus16.in_ready) low_rdy++;
    end
    chk($sformatf("vec%0d_latency", idx), lat, elat);
    chk($sformatf("vec%0d_busy_cycles", idx), low_rdy, elat - 1);
    chk($sformatf("vec%0d_out", idx), bus16.alu_out, eo);
    chk($sformatf("vec%0d_flags", idx), fl16(), efl);
    @(posedge clk); #1;
  endtask

  task automatic op8(input string name, input logic [3:0] f, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] eo, input logic [6:0] efl,
                     input int elat);
    int lat;
    bit seen;
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.alu_fun   = f;
    bus8.a         = a;
    bus8.b         = b;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus8.out_valid) seen = 1;
    end
    chk({name, "_latency"}, lat, elat);
    chk({name, "_out"}, bus8.alu_out, eo);
    chk({name, "_flags"}, fl8(), efl);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] eo;
    logic [6:0]  efl;
    logic [15:0] ra, rb;
    logic [3:0]  rf;
    logic [15:0] exp_o_q[$];
    logic [6:0]  exp_f_q[$];
    int          got, stale;

    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 7'b1000110, 1};
    vecs[1]  = '{OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 7'b1000010, 1};
    vecs[2]  = '{OP_ADD,  16'h1234, 16'h1111, 16'h2345, 7'b1000000, 1};
    vecs[3]  = '{OP_MUL,  16'h0100, 16'h0100, 16'h0000, 7'b1000110, 1};
    vecs[4]  = '{OP_MUL,  16'h0012, 16'h0034, 16'h03A8, 7'b1000000, 1};
    vecs[5]  = '{OP_DIV,  16'd1000, 16'd7,    16'd142,  7'b1000000, 17};
    vecs[6]  = '{OP_DIV,  16'd5,    16'd0,    16'hFFFF, 7'b1000001, 1};
    vecs[7]  = '{OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 7'b0100000, 1};
    vecs[8]  = '{OP_OR,   16'hF0F0, 16'h0F00, 16'hFFF0, 7'b0100000, 1};
    vecs[9]  = '{OP_NAND, 16'hFFFF, 16'hFFFF, 16'h0000, 7'b0100100, 1};
    vecs[10] = '{OP_NOR,  16'h0F00, 16'h00F0, 16'hF00F, 7'b0100000, 1};
    vecs[11] = '{OP_XOR,  16'hAAAA, 16'h5555, 16'hFFFF, 7'b0100000, 1};
    vecs[12] = '{OP_XNOR, 16'hAAAA, 16'hAAAA, 16'hFFFF, 7'b0100000, 1};
    vecs[13] = '{OP_EQ,   16'h0042, 16'h0042, 16'h0001, 7'b0010000, 1};
    vecs[14] = '{OP_GT,   16'h0005, 16'h0003, 16'h0002, 7'b0010000, 1};
    vecs[15] = '{OP_LT,   16'h0005, 16'h0003, 16'h0000, 7'b0010100, 1};
    vecs[16] = '{OP_SHR,  16'h8000, 16'h0013, 16'h1000, 7'b0001000, 1};
    vecs[17] = '{OP_SHL,  16'h0001, 16'h000F, 16'h8000, 7'b0001000, 1};
    vecs[18] = '{OP_NOP,  16'h1234, 16'h5678, 16'h0000, 7'b0000100, 1};
    vecs[19] = '{OP_DIV,  16'hFFFF, 16'h0001, 16'hFFFF, 7'b1000000, 17};
    vecs[20] = '{OP_SUB,  16'h0005, 16'h0005, 16'h0000, 7'b1000100, 1};
    vecs[21] = '{OP_DIV,  16'h0003, 16'h0007, 16'h0000, 7'b1000100, 17};

    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.alu_fun = '0;
    bus16.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.alu_fun = '0;
    bus8.out_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", bus16.out_valid, 0);
    chk("rst_alu_out", bus16.alu_out, 0);
    chk("rst_flags", fl16(), 0);
    chk("rst_in_ready", bus16.in_ready, 1);
    chk("rst8_out_valid", bus8.out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 22; i++)
      op16(i, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].eo, vecs[i].efl, vecs[i].lat);

    // Backpressure: result held, pending XOR waits, then consume+accept in one cycle
    bus16.out_ready = 1'b0;
    bus16.in_valid  = 1'b1;
    bus16.alu_fun   = OP_AND; bus16.a = 16'hF0F0; bus16.b = 16'hFF00;
    @(posedge clk); #1;
    bus16.alu_fun = OP_XOR; bus16.a = 16'h1234; bus16.b = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", bus16.out_valid, 1);
      chk("bp_hold_out", bus16.alu_out, 16'hF000);
      chk("bp_hold_flags", fl16(), 7'b0100000);
      chk("bp_in_ready_low", bus16.in_ready, 0);
      @(posedge clk); #1;
    end
    bus16.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_release", bus16.in_ready, 1);
    chk("bp_old_out", bus16.alu_out, 16'hF000);
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_new_valid", bus16.out_valid, 1);
    chk("bp_new_out", bus16.alu_out, 16'hEDCB);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_drained", bus16.out_valid, 0);
    @(posedge clk); #1;

    // Reset in the middle of a divide
    bus16.in_valid = 1'b1;
    bus16.alu_fun  = OP_DIV; bus16.a = 16'd100; bus16.b = 16'd7;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus16.out_valid, 0);
    chk("midrst_alu_out", bus16.alu_out, 0);
    chk("midrst_flags", fl16(), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", bus16.in_ready, 1);
    stale = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus16.out_valid) stale++;
    end
    chk("midrst_no_stale", stale, 0);
    @(posedge clk); #1;

    // Random back-to-back stream of non-divide ops
    got = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        do rf = 4'($urandom_range(0, 15)); while (rf == OP_DIV);
        ra = 16'($urandom);
        rb = (i % 5 == 0) ? ra : 16'($urandom);
        bus16.in_valid = 1'b1; bus16.alu_fun = rf; bus16.a = ra; bus16.b = rb;
        ref16(rf, ra, rb, eo, efl);
        exp_o_q.push_back(eo);
        exp_f_q.push_back(efl);
      end else begin
        bus16.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("stream_in_ready", bus16.in_ready, 1);
      chk($sformatf("stream_valid_%0d", i), bus16.out_valid, (i >= 1 && i <= 20) ? 1 : 0);
      if (bus16.out_valid && exp_o_q.size() > 0) begin
        eo  = exp_o_q.pop_front();
        efl = exp_f_q.pop_front();
        chk($sformatf("stream_out_%0d", got), bus16.alu_out, eo);
        chk($sformatf("stream_flags_%0d", got), fl16(), efl);
        got++;
      end
      @(posedge clk); #1;
    end
    chk("stream_count", got, 20);

    // 8-bit instance
    op8("w8_shl", OP_SHL, 8'h81, 8'h03, 8'h08, 7'b0001000, 1);
    op8("w8_mul", OP_MUL, 8'h10, 8'h10, 8'h00, 7'b1000110, 1);
    op8("w8_add", OP_ADD, 8'hFF, 8'h01, 8'h00, 7'b1000110, 1);
    op8("w8_div", OP_DIV, 8'd200, 8'd7, 8'd28, 7'b1000000, 9);
    op8("w8_div0", OP_DIV, 8'd9, 8'd0, 8'hFF, 7'b1000001, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
